// File: rtl/out_checker.sv
// Scoreboard checker: queues expected values, compares them against observations, reports pass/fail.
// Optional CHECKER_MONITOR_EN adds simulation-only mismatch and verdict printing; ports behave identically.
module out_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  output logic             exp_ready,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs_data,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             overrun,
  output logic [7:0]       mismatch_count,
  output logic [WIDTH-1:0] last_obs,
  output logic [1:0]       fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [IW-1:0]    r_idle;
  logic             r_timeout;
  logic             r_overrun;
  logic [7:0]       r_mm;
  logic [WIDTH-1:0] r_last;

  logic w_full, w_empty, w_in_check, w_obs, w_pop, w_orun, w_push;
  logic w_mis, w_idle_hit, w_last_pop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_in_check = (r_state == S_CHECK);
  assign w_obs      = w_in_check && obs_valid;
  assign w_pop      = w_obs && !w_empty;
  assign w_orun     = w_obs && w_empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign w_push     = exp_valid && (r_state != S_DONE) && (!w_full || w_pop);
  assign w_mis      = w_pop && (r_mem[r_rptr] != obs_data);
  assign w_idle_hit = w_in_check && !obs_valid && (r_idle == IW'(TIMEOUT - 1));
  assign w_last_pop = w_pop && !w_push && (r_count == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CHECK;
      S_CHECK: if (w_orun || w_last_pop || w_idle_hit) w_state_nxt = S_DONE;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wptr] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_idle    <= '0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_mm      <= 8'd0;
      r_last    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_in_check) r_idle <= obs_valid ? '0 : r_idle + 1'b1;
      if (w_idle_hit) r_timeout <= 1'b1;
      if (w_orun)     r_overrun <= 1'b1;
      if ((w_mis || w_orun) && (r_mm != 8'hFF)) r_mm <= r_mm + 8'd1;
      if (w_obs) r_last <= obs_data;
    end
  end

  assign exp_ready      = !w_full && (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_mm == 8'd0) && !r_timeout && !r_overrun;
  assign timeout        = r_timeout;
  assign overrun        = r_overrun;
  assign mismatch_count = r_mm;
  assign last_obs       = r_last;
  assign fsm_state      = r_state;

`ifdef CHECKER_MONITOR_EN
  int unsigned r_obs_idx;
  logic        r_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_obs_idx <= 0;
      r_done_q  <= 1'b0;
    end else begin
      r_done_q <= done;
      if (w_obs) r_obs_idx <= r_obs_idx + 1;
      if (w_mis)
        $display("out_checker: mismatch obs %0d exp=%h obs=%h", r_obs_idx, r_mem[r_rptr], obs_data);
      if (w_orun)
        $display("out_checker: mismatch obs %0d exp=<empty> obs=%h", r_obs_idx, obs_data);
      if (done && !r_done_q) $display("%s", pass ? "PASS" : "FAIL");
    end
  end
`endif

endmodule

// File: tb/tb_out_checker.sv
// Directed bench for out_checker with a queue-based reference model compared every cycle.
module tb_out_checker;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             exp_valid = 1'b0;
  logic [WIDTH-1:0] exp_data = '0;
  logic             exp_ready;
  logic             obs_valid = 1'b0;
  logic [WIDTH-1:0] obs_data = '0;
  logic             done, pass, timeout, overrun;
  logic [7:0]       mismatch_count;
  logic [WIDTH-1:0] last_obs;
  logic [1:0]       fsm_state;

  out_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .obs_valid(obs_valid), .obs_data(obs_data),
    .done(done), .pass(pass), .timeout(timeout), .overrun(overrun),
    .mismatch_count(mismatch_count), .last_obs(last_obs), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 checking, 2 finished.
  logic [31:0] m_q[$];
  int          m_phase = 0;
  int          m_next;
  int          m_mm = 0;
  int          m_idle = 0;
  bit          m_to = 0, m_or = 0, m_popped;
  int          m_size0;
  logic [31:0] m_last = '0;
  logic [31:0] m_head;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_phase = 0; m_mm = 0; m_idle = 0; m_to = 0; m_or = 0; m_last = '0;
    end else begin
      m_next   = m_phase;
      m_popped = 0;
      m_size0  = m_q.size();
      if (m_phase == 1 && obs_valid) begin
        m_last = obs_data;
        m_idle = 0;
        if (m_size0 == 0) begin
          m_or = 1;
          if (m_mm < 255) m_mm++;
          m_next = 2;
        end else begin
          m_head = m_q.pop_front();
          if (m_head != obs_data && m_mm < 255) m_mm++;
          m_popped = 1;
        end
      end else if (m_phase == 1) begin
        m_idle++;
        if (m_idle >= TIMEOUT) begin
          m_to = 1;
          m_next = 2;
        end
      end
      if (exp_valid && m_phase != 2 && (m_size0 < DEPTH || m_popped)) m_q.push_back(exp_data);
      if (m_popped && m_q.size() == 0) m_next = 2;
      if (m_phase == 0 && start) m_next = 1;
      m_phase = m_next;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("fsm_state", 32'(fsm_state), 32'(m_phase));
      check("done", 32'(done), 32'(m_phase == 2));
      check("pass", 32'(pass), 32'(m_phase == 2 && m_mm == 0 && !m_to && !m_or));
      check("timeout", 32'(timeout), 32'(m_to));
      check("overrun", 32'(overrun), 32'(m_or));
      check("mismatch_count", 32'(mismatch_count), 32'(m_mm));
      check("last_obs", last_obs, m_last);
      check("exp_ready", 32'(exp_ready), 32'(m_q.size() < DEPTH && m_phase != 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; exp_valid = 1'b0; obs_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    exp_valid = 1'b1; exp_data = v;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic observe(input logic [31:0] v);
    obs_valid = 1'b1; obs_data = v;
    tick();
    obs_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_exp_ready", 32'(exp_ready), 32'd1);
    check("rst_mm", 32'(mismatch_count), 32'd0);

    // Two matching values
    push(32'h34); push(32'h07); pulse_start();
    observe(32'h34);
    check("s1_mid_state", 32'(fsm_state), 32'd1);
    observe(32'h07);
    check("s1_done", 32'(done), 32'd1);
    check("s1_pass", 32'(pass), 32'd1);
    check("s1_mm", 32'(mismatch_count), 32'd0);
    check("s1_last", last_obs, 32'h07);
    pulse_start();
    check("s1_start_ignored", 32'(fsm_state), 32'd2);

    // Single mismatch
    do_reset();
    push(32'h07); pulse_start(); observe(32'h08);
    check("s2_done", 32'(done), 32'd1);
    check("s2_pass", 32'(pass), 32'd0);
    check("s2_mm", 32'(mismatch_count), 32'd1);

    // Timeout
    do_reset();
    push(32'h01); pulse_start();
    repeat (TIMEOUT - 1) tick();
    check("s3_pre_timeout", 32'(timeout), 32'd0);
    check("s3_pre_state", 32'(fsm_state), 32'd1);
    tick();
    check("s3_timeout", 32'(timeout), 32'd1);
    check("s3_done", 32'(done), 32'd1);
    check("s3_pass", 32'(pass), 32'd0);

    // Fill to full, ninth push dropped, then drain
    do_reset();
    exp_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_data = 32'h10 + i;
      tick();
    end
    check("s4_full_ready", 32'(exp_ready), 32'd0);
    exp_data = 32'hAA;
    tick();
    exp_valid = 1'b0;
    check("s4_still_full", 32'(exp_ready), 32'd0);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) observe(32'h10 + i);
    check("s4_done", 32'(done), 32'd1);
    check("s4_pass", 32'(pass), 32'd1);
    check("s4_last", last_obs, 32'h17);

    // Push into full FIFO coinciding with a pop is accepted
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h20 + i);
    pulse_start();
    exp_valid = 1'b1; exp_data = 32'h99; obs_valid = 1'b1; obs_data = 32'h20;
    tick();
    exp_valid = 1'b0; obs_valid = 1'b0;
    check("s5_still_full", 32'(exp_ready), 32'd0);
    for (int i = 1; i < DEPTH; i++) observe(32'h20 + i);
    check("s5_not_done", 32'(done), 32'd0);
    observe(32'h99);
    check("s5_pass", 32'(pass), 32'd1);

    // Overrun on empty FIFO
    do_reset();
    pulse_start(); observe(32'h05);
    check("s6_overrun", 32'(overrun), 32'd1);
    check("s6_mm", 32'(mismatch_count), 32'd1);
    check("s6_done", 32'(done), 32'd1);
    check("s6_last", last_obs, 32'h05);

    // Reset mid-check discards pending values; observation in IDLE ignored
    do_reset();
    push(32'hA1); push(32'hA2); push(32'hA3); pulse_start();
    observe(32'hA1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s7_state", 32'(fsm_state), 32'd0);
    check("s7_done", 32'(done), 32'd0);
    check("s7_last", last_obs, 32'd0);
    check("s7_mm", 32'(mismatch_count), 32'd0);
    check("s7_exp_ready", 32'(exp_ready), 32'd1);
    observe(32'h55);
    check("s7_idle_obs_ignored", last_obs, 32'd0);
    pulse_start(); observe(32'hA2);
    check("s7_fifo_emptied", 32'(overrun), 32'd1);

    // Mismatch count saturates; steady push+pop keeps one entry queued
    do_reset();
    push(32'h0); pulse_start();
    exp_valid = 1'b1; obs_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      exp_data = 32'(i + 1);
      obs_data = 32'hFFFF_0000 | 32'(i);
      tick();
    end
    exp_valid = 1'b0; obs_valid = 1'b0;
    check("s8_saturate", 32'(mismatch_count), 32'd255);
    check("s8_state", 32'(fsm_state), 32'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/out_checker.md
OUT_CHECKER -- requirements
Module: out_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data width of expected and observed values.
REQ-002 The block SHALL have parameter DEPTH, default 8, the expected-value FIFO depth (power of two, 2..64).
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the maximum idle cycles allowed between observations while in CHECK.
REQ-004 The block SHALL have port clk  input  1  the sole clock, rising-edge active.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port start  input  1  a one-cycle pulse that moves the FSM from IDLE to CHECK.
REQ-007 The block SHALL have ports exp_valid  input  1, exp_data  input  WIDTH, and exp_ready  output  1, the expected-value push handshake.
REQ-008 The block SHALL have ports obs_valid  input  1 and obs_data  input  WIDTH, the observed value from the unit under test, with no backpressure.
REQ-009 The block SHALL have ports done  output  1, pass  output  1, timeout  output  1, overrun  output  1, mismatch_count  output  8, last_obs  output  WIDTH, and fsm_state  output  2.

Function
REQ-010 The FSM SHALL have states IDLE=0, CHECK=1 and DONE=2, with the current state driven on fsm_state.
REQ-011 exp_ready SHALL be 1 when the FIFO is not full, in any state other than DONE.
REQ-012 An expected value SHALL be pushed on each cycle with exp_valid=1 and exp_ready=1; a push while full SHALL be dropped without changing state.
REQ-013 In IDLE, start=1 SHALL move the FSM to CHECK on the next edge; obs_valid SHALL be ignored in IDLE.
REQ-014 In CHECK, obs_valid=1 with the FIFO non-empty SHALL pop the head and compare it with obs_data, with a 1-cycle result latency.
REQ-015 On a compare, a mismatch SHALL increment mismatch_count, saturating at 255.
REQ-016 last_obs SHALL register obs_data on every accepted obs_valid.
REQ-017 In CHECK, obs_valid=1 with the FIFO empty SHALL set overrun sticky, increment mismatch_count, and move the FSM to DONE.
REQ-018 A simultaneous push and pop SHALL leave the FIFO count unchanged; a push into a full FIFO that coincides with a pop SHALL be accepted.
REQ-019 The FSM SHALL move from CHECK to DONE on the edge where a pop empties the FIFO and no push coincides.
REQ-020 An idle counter SHALL clear on each obs_valid in CHECK and otherwise increment; reaching TIMEOUT SHALL set timeout sticky and move the FSM to DONE.
REQ-021 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-022 done SHALL be 1 exactly while in DONE.
REQ-023 pass SHALL equal done AND mismatch_count==0 AND timeout==0 AND overrun==0.
REQ-024 DONE SHALL be held until reset; start SHALL be ignored in DONE.

Reset
REQ-025 While reset=1 at a rising edge, the block SHALL set fsm_state=IDLE, empty the FIFO, clear the idle counter, and drive done, pass, timeout, overrun, mismatch_count and last_obs to 0.
REQ-026 exp_ready SHALL be 1 on the first cycle after reset.
REQ-027 Reset SHALL take priority over start, push and observation in the same cycle, and reset asserted in CHECK SHALL discard all pending expected values.

Configuration
REQ-028 When CHECKER_MONITOR_EN is defined, the block SHALL print, via simulation display, the observation index, the expected value and the observed value in hex on each mismatch, and SHALL print "PASS" or "FAIL" once on entry to DONE.
REQ-029 When CHECKER_MONITOR_EN is undefined, the block SHALL contain no display statements, and its port behaviour SHALL be identical to the defined case.

Verification
REQ-030 Push 0x34 and 0x07, pulse start, then observe 0x34 and 0x07 on consecutive cycles -> done=1, pass=1, mismatch_count=0, last_obs=0x07.
REQ-031 Push 0x07, start, then observe 0x08 -> done=1, pass=0, mismatch_count=1.
REQ-032 Push 0x01, start, and apply no obs_valid for 16 cycles -> timeout=1, done=1, pass=0.
REQ-033 Push 8 values with exp_valid held on a 9th cycle -> exp_ready=0 after the 8th push and the 9th value is dropped; after start and 8 matching observations, pass=1.
REQ-034 With the FIFO empty, start then observe 0x05 -> overrun=1, mismatch_count=1, done=1.
REQ-035 Push 3 values, start, and assert reset after the first compare -> all outputs return to 0, fsm_state=IDLE, and exp_ready=1.
